regfile_wb_arbiter: RTL and testbench



---
 rtl/arm_wb_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/wb_starve_ctr.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/arm_wb_pkg.sv
// Shared definitions for the register-file write-back path: bus widths,
// the zero-register address and the grant-source encoding.
package arm_wb_pkg;

  localparam int REG_W  = 64;
  localparam int ADDR_W = 5;
  localparam int WAIT_W = 4;

  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'b11111;

  // Which requester owns the write slot this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } gnt_src_e;

  // Writes to the zero register are swallowed without using the write port.
  function automatic logic is_xzr(input logic [ADDR_W-1:0] rd);
    return rd == XZR_ADDR;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus: two valid/ready requesters in, register-file write
// controls out. The master side is the pipeline, the slave side the arbiter.
interface regfile_wb_arbiter_if;

  // ALU result path
  logic                            AluValid;
  logic [arm_wb_pkg::ADDR_W-1:0]   AluRd;
  logic [arm_wb_pkg::REG_W-1:0]    AluData;
  logic                            AluReady;

  // Load result path
  logic                            LdValid;
  logic [arm_wb_pkg::ADDR_W-1:0]   LdRd;
  logic [arm_wb_pkg::REG_W-1:0]    LdData;
  logic                            LdReady;

  // Register-file write port
  logic                            RegWr;
  logic [arm_wb_pkg::ADDR_W-1:0]   RW;
  logic [arm_wb_pkg::REG_W-1:0]    BusW;

  // Starvation counter, exported for debug and hazard logic
  logic [arm_wb_pkg::WAIT_W-1:0]   AluWaitCnt;

  modport master (
    output AluValid, AluRd, AluData,
    output LdValid, LdRd, LdData,
    input  AluReady, LdReady,
    input  RegWr, RW, BusW, AluWaitCnt
  );

  modport slave (
    input  AluValid, AluRd, AluData,
    input  LdValid, LdRd, LdData,
    output AluReady, LdReady,
    output RegWr, RW, BusW, AluWaitCnt
  );

endinterface

// File: rtl/wb_starve_ctr.sv
// Saturating wait counter. Counts cycles an ALU request has lost
// arbitration; at_max tells the arbiter to force the ALU through.
module wb_starve_ctr
  import arm_wb_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [WAIT_W-1:0] o_cnt,
  output logic              o_at_max
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX);

  logic [WAIT_W-1:0] r_cnt;

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == MAX_CNT);

  // Clear has priority; increment stops at MAX and holds there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Loads win contention (older in program order) until the ALU has lost
// MAX_WAIT times in a row; zero-register writes are accepted and dropped.
module regfile_wb_arbiter
  import arm_wb_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile_wb_arbiter_if.slave wb
);

  logic              w_alu_xzr;
  logic              w_ld_xzr;
  logic              w_alu_req;
  logic              w_ld_req;
  logic              w_at_max;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic [WAIT_W-1:0] w_wait_cnt;
  gnt_src_e          w_gnt;

  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_rw;
  logic [REG_W-1:0]  r_bus_w;

  // A request only competes for the write slot if it targets a real register.
  assign w_alu_xzr = is_xzr(wb.AluRd);
  assign w_ld_xzr  = is_xzr(wb.LdRd);
  assign w_alu_req = wb.AluValid & ~w_alu_xzr;
  assign w_ld_req  = wb.LdValid  & ~w_ld_xzr;

  // Pick the single write-slot owner from current requests and wait count.
  always_comb begin
    w_gnt = GNT_NONE;
    if (w_alu_req && w_ld_req) begin
      w_gnt = w_at_max ? GNT_ALU : GNT_LD;
    end else if (w_alu_req) begin
      w_gnt = GNT_ALU;
    end else if (w_ld_req) begin
      w_gnt = GNT_LD;
    end
  end

  // Ready never looks at the output register, so there is no loop back
  // from RegWr; zero-register requests are always taken immediately.
  assign wb.AluReady = ~Reset & wb.AluValid & (w_alu_xzr | (w_gnt == GNT_ALU));
  assign wb.LdReady  = ~Reset & wb.LdValid  & (w_ld_xzr  | (w_gnt == GNT_LD));

  // The counter only advances while a real ALU write is being held off;
  // any other situation (granted, idle, zero-register) restarts it.
  assign w_wait_inc = w_alu_req & (w_gnt != GNT_ALU);
  assign w_wait_clr = ~w_wait_inc;

  wb_starve_ctr #(
    .MAX (MAX_WAIT)
  ) u_starve_ctr (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_inc    (w_wait_inc),
    .i_clr    (w_wait_clr),
    .o_cnt    (w_wait_cnt),
    .o_at_max (w_at_max)
  );

  // Register the granted write; address and data hold when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_reg_wr <= 1'b0;
      r_rw     <= '0;
      r_bus_w  <= '0;
    end else begin
      case (w_gnt)
        GNT_ALU: begin
          r_reg_wr <= 1'b1;
          r_rw     <= wb.AluRd;
          r_bus_w  <= wb.AluData;
        end
        GNT_LD: begin
          r_reg_wr <= 1'b1;
          r_rw     <= wb.LdRd;
          r_bus_w  <= wb.LdData;
        end
        default: begin
          r_reg_wr <= 1'b0;
        end
      endcase
    end
  end

  assign wb.RegWr      = r_reg_wr;
  assign wb.RW         = r_rw;
  assign wb.BusW       = r_bus_w;
  assign wb.AluWaitCnt = w_wait_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with
// literal expectations plus a randomized phase against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 3;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  bit   chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .wb    (bus.slave)
  );

  always #5 Clk = ~Clk;

  // Behavioural model state
  bit          m_regwr;
  logic [4:0]  m_rw;
  logic [63:0] m_busw;
  int          m_cnt;
  bit          m_alu_acc;
  bit          m_ld_acc;
  logic [63:0] rf_model [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requests are accepted given the current inputs and wait count.
  function automatic logic [1:0] accept(input logic av, input logic [4:0] ard,
                                        input logic lv, input logic [4:0] lrd,
                                        input int cnt);
    bit a_req;
    bit l_req;
    bit alu_wins;
    bit ld_wins;
    a_req    = av && (ard != 5'd31);
    l_req    = lv && (lrd != 5'd31);
    alu_wins = a_req && (!l_req || cnt >= MAX_WAIT);
    ld_wins  = l_req && !alu_wins;
    return {av && (ard == 5'd31 || alu_wins), lv && (lrd == 5'd31 || ld_wins)};
  endfunction

  task automatic model_reset();
    m_regwr   = 0;
    m_rw      = '0;
    m_busw    = '0;
    m_cnt     = 0;
    m_alu_acc = 0;
    m_ld_acc  = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_update();
    logic [1:0] acc;
    if (Reset) begin
      model_reset();
      return;
    end
    acc       = accept(bus.AluValid, bus.AluRd, bus.LdValid, bus.LdRd, m_cnt);
    m_alu_acc = acc[1];
    m_ld_acc  = acc[0];
    if (m_alu_acc && bus.AluRd != 5'd31) begin
      m_regwr = 1; m_rw = bus.AluRd; m_busw = bus.AluData;
    end else if (m_ld_acc && bus.LdRd != 5'd31) begin
      m_regwr = 1; m_rw = bus.LdRd; m_busw = bus.LdData;
    end else begin
      m_regwr = 0;
    end
    if (bus.AluValid && bus.AluRd != 5'd31 && !m_alu_acc)
      m_cnt = (m_cnt < MAX_WAIT) ? m_cnt + 1 : MAX_WAIT;
    else
      m_cnt = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  // Compare process: every negedge, DUT against model; then the register
  // file model captures the write, as the real register file would.
  always @(negedge Clk) begin
    logic [1:0] acc;
    if (chk_en) begin
      acc = Reset ? 2'b00 : accept(bus.AluValid, bus.AluRd, bus.LdValid, bus.LdRd, m_cnt);
      check("alu_ready", bus.AluReady, acc[1]);
      check("ld_ready",  bus.LdReady,  acc[0]);
      check("regwr",     bus.RegWr,    m_regwr);
      check("rw",        bus.RW,       m_rw);
      check("busw",      bus.BusW,     m_busw);
      check("waitcnt",   bus.AluWaitCnt, 64'(m_cnt));
      if (!Reset && m_regwr) rf_model[m_rw] = m_busw;
    end
  end

  initial begin
    bus.AluValid = 0; bus.AluRd = '0; bus.AluData = '0;
    bus.LdValid  = 0; bus.LdRd  = '0; bus.LdData  = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    model_reset();

    // Reset values
    repeat (2) @(posedge Clk);
    #1;
    check("rst_regwr",   bus.RegWr, 0);
    check("rst_rw",      bus.RW, 0);
    check("rst_busw",    bus.BusW, 0);
    check("rst_waitcnt", bus.AluWaitCnt, 0);
    Reset  = 0;
    chk_en = 1;
    tick();

    // Single ALU write
    bus.AluValid = 1; bus.AluRd = 5'd5; bus.AluData = 64'hA5;
    #1;
    check("single_alu_ready", bus.AluReady, 1);
    tick();
    bus.AluValid = 0;
    check("single_regwr", bus.RegWr, 1);
    check("single_rw",    bus.RW, 5);
    check("single_busw",  bus.BusW, 64'hA5);
    tick();
    check("single_regwr_off", bus.RegWr, 0);

    // X31 dropped while the load proceeds in the same cycle
    bus.AluValid = 1; bus.AluRd = 5'd31; bus.AluData = 64'hDEAD;
    bus.LdValid  = 1; bus.LdRd  = 5'd7;  bus.LdData  = 64'h1;
    #1;
    check("x31_alu_ready", bus.AluReady, 1);
    check("x31_ld_ready",  bus.LdReady, 1);
    tick();
    bus.AluValid = 0; bus.LdValid = 0;
    check("x31_regwr", bus.RegWr, 1);
    check("x31_rw",    bus.RW, 7);
    check("x31_busw",  bus.BusW, 64'h1);
    tick();

    // Contention: load re-presents every cycle until the ALU is forced through
    bus.AluValid = 1; bus.AluRd = 5'd3; bus.AluData = 64'hAAA;
    for (int i = 0; i < 4; i++) begin
      bus.LdValid = 1; bus.LdRd = 5'(4 + i); bus.LdData = 64'(100 + i);
      #1;
      check("cont_alu_ready", bus.AluReady, (i == 3) ? 1 : 0);
      check("cont_ld_ready",  bus.LdReady,  (i == 3) ? 0 : 1);
      tick();
      check("cont_waitcnt", bus.AluWaitCnt, (i == 3) ? 0 : i + 1);
    end
    bus.AluValid = 0;
    check("cont_alu_rw", bus.RW, 3);
    tick();
    bus.LdValid = 0;
    tick();

    // Same Rd on both ports: load first, ALU second, ALU value survives
    bus.AluValid = 1; bus.AluRd = 5'd9; bus.AluData = 64'h11;
    bus.LdValid  = 1; bus.LdRd  = 5'd9; bus.LdData  = 64'h22;
    tick();
    bus.LdValid = 0;
    check("same_first_regwr", bus.RegWr, 1);
    check("same_first_busw",  bus.BusW, 64'h22);
    tick();
    bus.AluValid = 0;
    check("same_second_regwr", bus.RegWr, 1);
    check("same_second_busw",  bus.BusW, 64'h11);
    @(negedge Clk);
    #1;
    check("same_final_reg9", rf_model[9], 64'h11);
    tick();

    // Reset mid-stream with a write pending
    bus.AluValid = 1; bus.AluRd = 5'd12; bus.AluData = 64'h1234;
    tick();
    bus.AluValid = 0;
    bus.LdValid = 1; bus.LdRd = 5'd6; bus.LdData = 64'h66;
    check("midrst_pre_regwr", bus.RegWr, 1);
    #2;
    Reset = 1;
    model_reset();
    #1;
    check("midrst_regwr",   bus.RegWr, 0);
    check("midrst_rw",      bus.RW, 0);
    check("midrst_busw",    bus.BusW, 0);
    check("midrst_waitcnt", bus.AluWaitCnt, 0);
    check("midrst_ld_ready", bus.LdReady, 0);
    tick();
    tick();
    Reset = 0;
    #1;
    check("postrst_ld_ready", bus.LdReady, 1);
    tick();
    bus.LdValid = 0;
    check("postrst_rw",   bus.RW, 6);
    check("postrst_busw", bus.BusW, 64'h66);
    tick();

    // Randomized traffic obeying the hold-until-ready rule
    m_alu_acc = 0; m_ld_acc = 0;
    for (int c = 0; c < 400; c++) begin
      if (!bus.AluValid || m_alu_acc) begin
        bus.AluValid = ($urandom_range(0, 3) != 0);
        bus.AluRd    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(1, 8));
        bus.AluData  = {$urandom, $urandom};
      end
      if (!bus.LdValid || m_ld_acc) begin
        bus.LdValid = ($urandom_range(0, 2) != 0);
        bus.LdRd    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(1, 8));
        bus.LdData  = {$urandom, $urandom};
      end
      tick();
    end

    bus.AluValid = 0; bus.LdValid = 0;
    repeat (3) tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
